// File: rtl/seq_multiplier_pkg.sv
// -----------------------------------------------------------------------------
// seq_multiplier_pkg
// Shared definitions for the shift-add multiplier and the execute-stage logic
// around it (ALU control, HI/LO stage).
//   - state_t      : multiplier FSM encoding (IDLE/MUL/DONE)
//   - DEFAULT_WIDTH: default operand width
//   - FUNCT_MULTU  : funct code the ALU control decodes to raise start
// -----------------------------------------------------------------------------
package seq_multiplier_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [5:0] FUNCT_MULTU = 6'b011001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_multiplier_mul_add_shift.sv
// -----------------------------------------------------------------------------
// mul_add_shift
// One combinational shift-add step of the unsigned multiplier.
// Ports:
//   i_prod      : current product register {upper accumulator, remaining multiplier}
//   i_mcand     : multiplicand
//   o_prod_next : product register after one step
// -----------------------------------------------------------------------------
module mul_add_shift
    import seq_multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [2*WIDTH-1:0] i_prod,
    input  logic [WIDTH-1:0]   i_mcand,
    output logic [2*WIDTH-1:0] o_prod_next
);

    // One extra bit so the carry out of the upper-half add is kept and shifted
    // into the top of the product instead of being lost.
    logic [WIDTH:0] w_sum;

    always_comb begin
        w_sum       = {1'b0, i_prod[2*WIDTH-1:WIDTH]}
                    + (i_prod[0] ? {1'b0, i_mcand} : '0);
        o_prod_next = {w_sum, i_prod[WIDTH-1:1]};
    end

endmodule

// File: rtl/seq_multiplier.sv
// -----------------------------------------------------------------------------
// seq_multiplier
// Sequential shift-add unsigned multiplier, one partial-product step per clock,
// with a start/busy/done handshake. Result is exact (2*WIDTH bits).
// Ports:
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   start   : request a multiply, only honoured in IDLE
//   dataA   : multiplicand (unsigned), sampled at the accepted start edge
//   dataB   : multiplier (unsigned), sampled at the accepted start edge
//   busy    : high whenever the FSM is not IDLE
//   done    : one-cycle pulse, product is final in this cycle
//   product : product register; holds the last result while IDLE
// -----------------------------------------------------------------------------
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   dataA,
    input  logic [WIDTH-1:0]   dataB,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int              CNT_W     = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [WIDTH-1:0]     r_mcand;
    logic [2*WIDTH-1:0]   r_prod;
    logic [2*WIDTH-1:0]   w_prod_step;

    mul_add_shift #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_prod      (r_prod),
        .i_mcand     (r_mcand),
        .o_prod_next (w_prod_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // busy/done decode the registered state only, so start never reaches
    // them combinationally.
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = MUL;
                end
            end
            MUL: begin
                busy = 1'b1;
                if (r_cnt == LAST_STEP) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // The multiplier operand lives in the low half of the product register and
    // is consumed one bit per step as the accumulator shifts in from the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_mcand <= '0;
            r_prod  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_mcand <= dataA;
                        r_prod  <= {{WIDTH{1'b0}}, dataB};
                        r_cnt   <= '0;
                    end
                end
                MUL: begin
                    r_prod <= w_prod_step;
                    r_cnt  <= r_cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign product = r_prod;

endmodule
